// File: rtl/mac_seq_pkg.sv
// Shared types and width helpers for the MAC tile sequencer.
package mac_seq_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

  typedef enum logic {SEQ = 1'b0, PIPE = 1'b1} mode_t;

  // Index ports address 0..size-1; dimension ports also need to hold size itself.
  function automatic int idx_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int cnt_width(input int size);
    return idx_width(size) + 1;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Command/strobe bundle between the front end (master) and the tile sequencer (slave).
interface mac_seq_ctrl_if #(
  parameter int SIZE = 16
);
  import mac_seq_pkg::*;

  localparam int CW = cnt_width(SIZE);
  localparam int IW = idx_width(SIZE);

  logic          start;
  logic          abort;
  logic          mode;
  logic [CW-1:0] rows_in;
  logic [CW-1:0] cols_in;
  logic [CW-1:0] k_in;
  logic          busy;
  logic          load_en;
  logic          mult_en;
  logic          acc_en;
  logic          acc_clr;
  logic [SIZE-1:0] memsel;
  logic [IW-1:0] row_idx;
  logic [IW-1:0] col_idx;
  logic [IW-1:0] k_idx;
  logic          wr_en;
  logic          done;
  logic          cfg_err;

  modport master (
    output start, abort, mode, rows_in, cols_in, k_in,
    input  busy, load_en, mult_en, acc_en, acc_clr, memsel,
           row_idx, col_idx, k_idx, wr_en, done, cfg_err
  );

  modport slave (
    input  start, abort, mode, rows_in, cols_in, k_in,
    output busy, load_en, mult_en, acc_en, acc_clr, memsel,
           row_idx, col_idx, k_idx, wr_en, done, cfg_err
  );

endinterface

// File: rtl/mac_phase_gen.sv
// Turns one-per-k-step requests into registered load/mult/acc strobes via a 2-deep delay line.
module mac_phase_gen
  import mac_seq_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  step,
  input  logic  first,
  input  logic  flush,
  input  mode_t mode,
  output logic  ready,
  output logic  load_en,
  output logic  mult_en,
  output logic  acc_en,
  output logic  acc_clr
);

  // Mult and acc trail load by one and two cycles in both modes; a flush empties the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_en <= 1'b0;
      mult_en <= 1'b0;
      acc_en  <= 1'b0;
      acc_clr <= 1'b0;
    end else if (flush) begin
      load_en <= 1'b0;
      mult_en <= 1'b0;
      acc_en  <= 1'b0;
      acc_clr <= 1'b0;
    end else begin
      load_en <= step;
      mult_en <= load_en;
      acc_en  <= mult_en;
      acc_clr <= step & first;
    end
  end

  // Sequential mode holds off the next step until the current one has reached its A phase.
  assign ready = (mode == PIPE) || !(load_en || mult_en);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Tile sequencer: walks rows x cols output elements, each a k-step MAC followed by a writeback.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int SIZE = 16
) (
  input logic clk,
  input logic reset,
  mac_seq_ctrl_if.slave bus
);

  localparam int CW = cnt_width(SIZE);
  localparam int IW = idx_width(SIZE);
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [IW-1:0] ONE_I  = IW'(1);

  state_t        state, next_state;
  mode_t         mode_q;
  logic [CW-1:0] rows_q, cols_q, k_q;
  logic [IW-1:0] row_cnt, col_cnt, k_cnt;
  logic [IW-1:0] row_nxt, col_nxt, k_nxt;
  logic          drain_cnt, drain_nxt;
  logic [SIZE-1:0] memsel_q;
  logic          busy_q, wr_q, done_q, err_q;
  logic          step, first, flush, err_nxt, gen_ready;
  logic          k_last, row_last, col_last, dims_ok;

  function automatic logic dim_ok(input logic [CW-1:0] d);
    return (d != '0) && (d <= SIZE_C);
  endfunction

  assign dims_ok  = dim_ok(bus.rows_in) && dim_ok(bus.cols_in) && dim_ok(bus.k_in);
  assign k_last   = ({1'b0, k_cnt} + ONE_C) == k_q;
  assign row_last = ({1'b0, row_cnt} + ONE_C) == rows_q;
  assign col_last = ({1'b0, col_cnt} + ONE_C) == cols_q;

  always_comb begin
    next_state = state;
    row_nxt    = row_cnt;
    col_nxt    = col_cnt;
    k_nxt      = k_cnt;
    drain_nxt  = drain_cnt;
    step       = 1'b0;
    first      = 1'b0;
    flush      = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          row_nxt = '0;
          col_nxt = '0;
          k_nxt   = '0;
          if (dims_ok) begin
            next_state = RUN;
            step       = 1'b1;
            first      = 1'b1;
          end else begin
            next_state = DONE;
            err_nxt    = 1'b1;
          end
        end
      end
      RUN: begin
        if (gen_ready) begin
          if (k_last) begin
            next_state = (mode_q == PIPE) ? DRAIN : WRITE;
            drain_nxt  = 1'b0;
          end else begin
            k_nxt = k_cnt + ONE_I;
            step  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt) next_state = WRITE;
        else           drain_nxt  = 1'b1;
      end
      WRITE: begin
        k_nxt      = '0;
        next_state = RUN;
        step       = 1'b1;
        first      = 1'b1;
        if (!col_last) begin
          col_nxt = col_cnt + ONE_I;
        end else begin
          col_nxt = '0;
          if (row_last) begin
            row_nxt    = '0;
            next_state = DONE;
            step       = 1'b0;
            first      = 1'b0;
          end else begin
            row_nxt = row_cnt + ONE_I;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Abort wins over everything the element was about to do, including its writeback.
    if (bus.abort && (state inside {RUN, DRAIN, WRITE})) begin
      next_state = IDLE;
      step       = 1'b0;
      first      = 1'b0;
      flush      = 1'b1;
      row_nxt    = '0;
      col_nxt    = '0;
      k_nxt      = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= SEQ;
      rows_q    <= '0;
      cols_q    <= '0;
      k_q       <= '0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      k_cnt     <= '0;
      drain_cnt <= 1'b0;
      memsel_q  <= '0;
      busy_q    <= 1'b0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= next_state;
      row_cnt   <= row_nxt;
      col_cnt   <= col_nxt;
      k_cnt     <= k_nxt;
      drain_cnt <= drain_nxt;
      if (state == IDLE && bus.start) begin
        mode_q <= mode_t'(bus.mode);
        rows_q <= bus.rows_in;
        cols_q <= bus.cols_in;
        k_q    <= bus.k_in;
      end
      busy_q <= (next_state != IDLE);
      wr_q   <= (next_state == WRITE);
      done_q <= (next_state == DONE);
      err_q  <= (next_state == DONE) && err_nxt;
      // memsel fills one lane per load and survives through the writeback cycle.
      if (next_state == IDLE)
        memsel_q <= '0;
      else if (step)
        memsel_q <= first ? {{(SIZE-1){1'b0}}, 1'b1} : {memsel_q[SIZE-2:0], 1'b1};
      else if (state == WRITE)
        memsel_q <= '0;
    end
  end

  mac_phase_gen u_phase (
    .clk     (clk),
    .reset   (reset),
    .step    (step),
    .first   (first),
    .flush   (flush),
    .mode    (mode_q),
    .ready   (gen_ready),
    .load_en (bus.load_en),
    .mult_en (bus.mult_en),
    .acc_en  (bus.acc_en),
    .acc_clr (bus.acc_clr)
  );

  assign bus.busy    = busy_q;
  assign bus.wr_en   = wr_q;
  assign bus.done    = done_q;
  assign bus.cfg_err = err_q;
  assign bus.memsel  = memsel_q;
  assign bus.row_idx = row_cnt;
  assign bus.col_idx = col_cnt;
  assign bus.k_idx   = k_cnt;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: expected active cycles are queued at start, a negedge monitor pops them.
module tb_mac_seq_ctrl;

  localparam int SIZE = 16;
  localparam int BIG  = 1 << 30;

  typedef struct packed {
    int          c;
    logic        busy, ld, mu, ac, clr, wr, dn, err;
    logic [3:0]  row, col, k;
    logic [15:0] ms;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];

  mac_seq_ctrl_if #(.SIZE(SIZE)) bus();

  mac_seq_ctrl #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ones(input int n);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic string fmt(input ev_t e);
    return $sformatf("cyc=%0d busy=%b ld=%b mu=%b ac=%b clr=%b wr=%b done=%b err=%b row=%0d col=%0d k=%0d memsel=%h",
                     e.c, e.busy, e.ld, e.mu, e.ac, e.clr, e.wr, e.dn, e.err, e.row, e.col, e.k, e.ms);
  endfunction

  function automatic void push_ev(input int c, input int upto, input logic ld, mu, ac, clr, wr, dn, err,
                                  input int row, col, k, input logic [15:0] ms);
    ev_t e;
    if (c > upto) return;
    e.c = c; e.busy = 1'b1; e.ld = ld; e.mu = mu; e.ac = ac; e.clr = clr;
    e.wr = wr; e.dn = dn; e.err = err;
    e.row = 4'(row); e.col = 4'(col); e.k = 4'(k); e.ms = ms;
    exp_q.push_back(e);
  endfunction

  // Expected activity of a legal tile started in cycle c0, from the per-element timing P.
  function automatic void push_run(input int c0, input logic m, input int r, c, k, upto);
    int p, base, kk;
    p = m ? k + 3 : 3 * k + 1;
    for (int e = 0; e < r * c; e++) begin
      base = c0 + 1 + e * p;
      if (!m) begin
        for (int s = 0; s < k; s++) begin
          push_ev(base + 3*s,     upto, 1, 0, 0, s == 0, 0, 0, 0, e / c, e % c, s, ones(s + 1));
          push_ev(base + 3*s + 1, upto, 0, 1, 0, 0,      0, 0, 0, e / c, e % c, s, ones(s + 1));
          push_ev(base + 3*s + 2, upto, 0, 0, 1, 0,      0, 0, 0, e / c, e % c, s, ones(s + 1));
        end
      end else begin
        for (int j = 0; j <= k + 1; j++) begin
          kk = (j < k) ? j : k - 1;
          push_ev(base + j, upto, j < k, (j >= 1) && (j <= k), j >= 2, j == 0, 0, 0, 0,
                  e / c, e % c, kk, ones((j + 1 < k) ? j + 1 : k));
        end
      end
      push_ev(base + p - 1, upto, 0, 0, 0, 0, 1, 0, 0, e / c, e % c, k - 1, ones(k));
    end
    push_ev(c0 + 1 + r * c * p, upto, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
  endfunction

  // Monitor: every cycle with a strobe must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t act, ex;
    if ({bus.load_en, bus.mult_en, bus.acc_en, bus.acc_clr, bus.wr_en, bus.done, bus.cfg_err} !== 7'b0) begin
      act.c = cyc; act.busy = bus.busy; act.ld = bus.load_en; act.mu = bus.mult_en;
      act.ac = bus.acc_en; act.clr = bus.acc_clr; act.wr = bus.wr_en; act.dn = bus.done;
      act.err = bus.cfg_err; act.row = bus.row_idx; act.col = bus.col_idx; act.k = bus.k_idx;
      act.ms = bus.memsel;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL unexpected_event: got {%s} required no activity", fmt(act));
      end else begin
        ex = exp_q.pop_front();
        if (act !== ex) begin
          n_bad++;
          $display("[TB] FAIL event: got {%s} required {%s}", fmt(act), fmt(ex));
        end
      end
    end
  end

  task automatic apply_stimulus(input logic m, input int r, c, k);
    bus.mode    = m;
    bus.rows_in = 5'(r);
    bus.cols_in = 5'(c);
    bus.k_in    = 5'(k);
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
  endtask

  task automatic check_output(input string name);
    logic [36:0] v;
    v = {bus.busy, bus.load_en, bus.mult_en, bus.acc_en, bus.acc_clr, bus.wr_en, bus.done,
         bus.cfg_err, bus.memsel, bus.row_idx, bus.col_idx, bus.k_idx, 1'b0};
    n_cmp++;
    if (v !== '0) begin
      n_bad++;
      $display("[TB] FAIL %s: outputs=%h required all zero", name, v);
    end
  endtask

  task automatic wait_quiet(input int limit, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL %s_timeout: pending=%0d busy=%b after %0d cycles, required 0 pending and idle",
               name, exp_q.size(), bus.busy, limit);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0;
    bus.rows_in = '0; bus.cols_in = '0; bus.k_in = '0;
    repeat (3) @(posedge clk); #1;
    check_output("reset_hold");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check_output("reset_state");

    $display("[TB] sequential 2x2x3, start pulsed again during DONE");
    c0 = cyc;
    push_run(c0, 1'b0, 2, 2, 3, BIG);
    apply_stimulus(1'b0, 2, 2, 3);
    repeat (40) @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = 1'b1; bus.rows_in = 5'd1; bus.cols_in = 5'd1; bus.k_in = 5'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_quiet(60, "seq");
    repeat (4) @(posedge clk); #1;
    check_output("seq_idle");

    $display("[TB] pipelined 2x2x3, mode pin toggled while busy");
    c0 = cyc;
    push_run(c0, 1'b1, 2, 2, 3, BIG);
    apply_stimulus(1'b1, 2, 2, 3);
    @(posedge clk); #1;
    bus.mode = 1'b0;
    wait_quiet(60, "pipe");
    check_output("pipe_idle");

    $display("[TB] illegal dimensions");
    c0 = cyc;
    push_ev(c0 + 1, BIG, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0000);
    apply_stimulus(1'b0, 2, 2, 0);
    wait_quiet(10, "cfg_k0");
    check_output("cfg_k0_idle");
    c0 = cyc;
    push_ev(c0 + 1, BIG, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0000);
    apply_stimulus(1'b1, 17, 2, 2);
    wait_quiet(10, "cfg_rows17");
    check_output("cfg_rows17_idle");

    $display("[TB] abort in cycle 5, restart in cycle 7");
    c0 = cyc;
    push_run(c0, 1'b0, 2, 2, 3, c0 + 5);
    apply_stimulus(1'b0, 2, 2, 3);
    repeat (4) @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_output("abort_next");
    @(posedge clk); #1;
    c0 = cyc;
    push_run(c0, 1'b0, 1, 1, 2, BIG);
    apply_stimulus(1'b0, 1, 1, 2);
    wait_quiet(40, "post_abort");
    check_output("post_abort_idle");

    $display("[TB] async reset mid-DRAIN with start while busy");
    c0 = cyc;
    push_run(c0, 1'b1, 2, 2, 3, c0 + 4);
    apply_stimulus(1'b1, 2, 2, 3);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.rows_in = 5'd1; bus.cols_in = 5'd1; bus.k_in = 5'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check_output("async_reset");
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (6) @(posedge clk); #1;
    check_output("after_reset");

    $display("[TB] boundary 16x16x1 pipelined");
    c0 = cyc;
    push_run(c0, 1'b1, 16, 16, 1, BIG);
    apply_stimulus(1'b1, 16, 16, 1);
    wait_quiet(1100, "boundary");
    check_output("boundary_idle");

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL leftover: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Parametrised sequencer for the matrix processor's MAC datapath. It generalises the fixed load/multiply/accumulate controller to a full rows×cols×k tile walk, and adds a pipelined issue mode, accumulator-clear and result-writeback strobes, operand indices, abort and configuration-error reporting. It sits between the command front end, which supplies start and dimensions, and the MAC unit plus operand/result memories.

## Interface
Parameters:
- SIZE, 16, maximum matrix dimension; all dimension ports are $clog2(SIZE)+1 bits (CW) and index ports are $clog2(SIZE) bits (IW).

Ports. Clock `clk`; reset `reset`, asynchronous, active-high. One clock.
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  begin a tile; sampled only in IDLE
- abort  in  1  synchronous cancel of the running tile
- mode  in  1  0 = sequential (3 cycles per k step), 1 = pipelined (1 k step per cycle)
- rows_in, cols_in, k_in  in  CW each  tile dimensions; captured on accepted start
- busy  out  1  high from accepted start until the done or abort cycle inclusive
- load_en, mult_en, acc_en  out  1 each  MAC phase strobes
- acc_clr  out  1  with load_en when k_idx==0
- memsel  out  SIZE  thermometer of operand lanes loaded for the current element
- row_idx, col_idx, k_idx  out  IW each  current operand coordinates
- wr_en  out  1  result writeback strobe for (row_idx, col_idx)
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  high with done when the dimensions were illegal

## Operation
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE: start=1 captures mode and dimensions and zeroes the indices. Legal dimensions (all in 1..SIZE) -> RUN. Otherwise -> DONE with cfg_err=1 and no strobes.
- RUN, sequential: each k step is three cycles, L/M/A.
  - L: load_en=1, memsel <= {memsel[SIZE-2:0],1'b1}.
  - M: mult_en=1.
  - A: acc_en=1.
  - After A of k_idx==k_in-1 -> WRITE; otherwise k_idx++ and return to L.
- RUN, pipelined: load_en every cycle for k_in cycles, with k_idx incrementing. mult_en is load_en delayed 1 cycle; acc_en is load_en delayed 2 cycles. After the last load -> DRAIN for 2 cycles -> WRITE.
- WRITE: one cycle with wr_en=1 and memsel cleared.
  - Advance col_idx. On wrap to 0, advance row_idx.
  - If that was the last element -> DONE; otherwise -> RUN with k_idx=0.
- DONE: done=1 for one cycle -> IDLE; busy drops the following cycle.
- Phase strobes are mutually exclusive in sequential mode. In pipelined mode they may overlap, but at most one of each is active per cycle.
- start while busy is ignored.
- abort in RUN, DRAIN or WRITE: the next cycle has all strobes low, no wr_en and no done, and the FSM is in IDLE. abort in the same cycle as a WRITE suppresses that wr_en.
- abort in IDLE or DONE has no effect.
- Reset mid-operation: immediate return to IDLE, all outputs 0.
- mode is changed only at start; a change of the mode pin while busy is ignored.

## Timing
- Reset value of every output: 0. Index registers: 0. State: IDLE.
- All outputs are registered.
- start sampled at the edge ending cycle 0. The first load_en appears in cycle 1.
- Per element, P = 3·k+1 cycles (sequential) or P = k+3 cycles (pipelined), with N = rows·cols elements.
- Element e starts in cycle 1+e·P; wr_en falls in cycle e·P+P; done in cycle 1+N·P.
- cfg_err path: done and cfg_err in cycle 1.
- k_idx is valid with load_en; row_idx and col_idx are stable for the whole element, including its WRITE cycle.
- Counter widths: CW-bit counters compared against captured dimensions; no overflow is possible since dimensions ≤ SIZE.

## Structure
- Package mac_seq_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, WRITE, DONE);
  - the mode enum (SEQ, PIPE);
  - a CW/IW width helper function.
- Sub-module mac_phase_gen generates load_en/mult_en/acc_en/acc_clr from a step request and mode, including the 2-deep delay line for pipelined mode.
- The top level holds the FSM, dimension capture, index counters and memsel.

## Test plan
- Sequential run, rows=2, cols=2, k=3, start at cycle 0 -> load_en in cycles 1,4,7; wr_en in cycles 10,20,30,40 with (row,col) = (0,0),(0,1),(1,0),(1,1); done in cycle 41; memsel=0x0007 at each wr_en.
- Pipelined run, same dimensions -> load_en in cycles 1–3, mult_en in 2–4, acc_en in 3–5, wr_en in cycles 6,12,18,24, done in cycle 25; acc_clr only in cycles 1,7,13,19.
- Illegal dimensions, k_in=0 and separately rows_in=17 (SIZE=16) -> done=1 and cfg_err=1 in cycle 1, no strobes, busy high only in cycle 1.
- abort in cycle 5 of a sequential 2×2×3 run -> from cycle 6 all outputs 0, no done, and a start in cycle 7 is accepted.
- Asynchronous reset pulse mid-DRAIN, plus start pulsed while busy -> outputs 0 immediately; the start during busy produces no second run.
- Boundary case k=1, rows=cols=SIZE, pipelined -> 256 wr_en pulses, row_idx wraps correctly at 15, done in cycle 1+256·4=1025.
